mem_addr_seq: RTL and testbench

- Parametrised, registered successor to the IorD memory-address select.
- Captures one of NUM_SRC address sources, or an exception-vector address, and drives the memory address and read strobe.
- Sequences single-word or multi-beat accesses, inserting MEM_LAT wait cycles per beat.
- Sits between the multi-cycle control unit and the memory; signals completion back to control.

---
 rtl/mem_addr_seq.sv | 119 +++++++++++
 tb/tb_mem_addr_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_addr_seq.sv
// Registered memory-address sequencer: picks a source or exception vector,
// then issues single or multi-beat reads with MEM_LAT wait cycles per beat.
module mem_addr_seq #(
  parameter int ADDR_W    = 32,
  parameter int NUM_SRC   = 6,
  parameter int SEL_W     = 3,
  parameter int VEC_BASE  = 253,
  parameter int STRIDE    = 4,
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic                      start,
  input  logic [2:0]                burst_len,
  input  logic                      exc_req,
  input  logic [1:0]                exc_code,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd,
  output logic                      beat_valid,
  output logic [2:0]                beat_idx,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] LAT  = 2'(MEM_LAT);
  localparam logic [2:0] MAXB = 3'(MAX_BURST);

  state_t            state;
  logic [1:0]        wait_cnt;
  logic [2:0]        last_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] vec_addr;
  logic [ADDR_W-1:0] acc_addr;
  logic [2:0]        acc_last;
  logic              beat_end;
  logic              last_beat;

  // Out-of-range selects fall through to address 0.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) sel_addr = src_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    vec_addr = ADDR_W'(VEC_BASE) + ADDR_W'((exc_code == 2'd3) ? 2'd2 : exc_code);
    acc_addr = exc_req ? vec_addr : sel_addr;
    if (exc_req || burst_len == 3'd0) acc_last = 3'd0;
    else if (burst_len > MAXB)        acc_last = MAXB - 3'd1;
    else                              acc_last = burst_len - 3'd1;
  end

  // beat_end marks the cycle in which the current beat's data is valid.
  assign beat_end  = (state == ISSUE && LAT == 2'd0) || (state == WAIT && wait_cnt == LAT);
  assign last_beat = (beat_idx == last_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      beat_valid <= 1'b0;
      beat_idx   <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wait_cnt   <= 2'd0;
      last_idx   <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (exc_req || start) begin
            state      <= ISSUE;
            mem_addr   <= acc_addr;
            last_idx   <= acc_last;
            beat_idx   <= 3'd0;
            mem_rd     <= 1'b1;
            busy       <= 1'b1;
            beat_valid <= (LAT == 2'd0);
          end
        end
        ISSUE, WAIT: begin
          if (beat_end) begin
            if (last_beat) begin
              state      <= DONE;
              mem_rd     <= 1'b0;
              beat_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              state      <= ISSUE;
              mem_addr   <= mem_addr + ADDR_W'(STRIDE);
              beat_idx   <= beat_idx + 3'd1;
              mem_rd     <= 1'b1;
              beat_valid <= (LAT == 2'd0);
            end
          end else if (state == ISSUE) begin
            state      <= WAIT;
            wait_cnt   <= 2'd1;
            mem_rd     <= 1'b0;
            beat_valid <= (LAT == 2'd1);
          end else begin
            wait_cnt   <= wait_cnt + 2'd1;
            beat_valid <= (wait_cnt + 2'd1 == LAT);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_addr_seq.sv
// Randomized self-checking bench for mem_addr_seq: each access is expanded
// into a per-cycle list of expected outputs and compared cycle by cycle.
module tb_mem_addr_seq;

  localparam int ADDR_W = 32;
  localparam int NSRC   = 6;
  localparam int LAT    = 1;
  localparam int VEC    = 253;

  typedef struct {
    logic [31:0] addr;
    bit          rd;
    bit          valid;
    bit          busy;
    bit          done;
    logic [2:0]  idx;
  } cyc_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [2:0]             sel = '0;
  logic [NSRC*ADDR_W-1:0] src_addr = '0;
  logic                   start = 1'b0;
  logic [2:0]             burst_len = '0;
  logic                   exc_req = 1'b0;
  logic [1:0]             exc_code = '0;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_rd;
  logic                   beat_valid;
  logic [2:0]             beat_idx;
  logic                   busy;
  logic                   done;

  logic [31:0] src_vals [NSRC];
  int n_checks = 0;
  int n_fail   = 0;

  mem_addr_seq #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .sel(sel), .src_addr(src_addr),
    .start(start), .burst_len(burst_len), .exc_req(exc_req), .exc_code(exc_code),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .beat_valid(beat_valid),
    .beat_idx(beat_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit do_start, input bit do_exc, input logic [2:0] s,
                                input logic [2:0] bl, input logic [1:0] code);
    start     = do_start;
    exc_req   = do_exc;
    sel       = s;
    burst_len = bl;
    exc_code  = code;
    for (int i = 0; i < NSRC; i++) src_addr[i*ADDR_W +: ADDR_W] = src_vals[i];
  endtask

  task automatic check_cycle(input string tag, input cyc_t e);
    check_output({tag, ".addr"},  mem_addr, e.addr);
    check_output({tag, ".rd"},    32'(mem_rd), 32'(e.rd));
    check_output({tag, ".valid"}, 32'(beat_valid), 32'(e.valid));
    check_output({tag, ".busy"},  32'(busy), 32'(e.busy));
    check_output({tag, ".done"},  32'(done), 32'(e.done));
    if (e.busy) check_output({tag, ".idx"}, 32'(beat_idx), 32'(e.idx));
  endtask

  // Runs one access; abort_at > 0 pulls reset low during that cycle.
  task automatic run_access(input string tag, input bit do_start, input bit do_exc,
                            input logic [2:0] s, input logic [2:0] bl,
                            input logic [1:0] code, input int abort_at);
    cyc_t        exp_q[$];
    cyc_t        c;
    logic [31:0] base;
    int          beats;
    int          ce;
    if (do_exc) begin
      ce    = (code == 2'd3) ? 2 : int'(code);
      base  = 32'(VEC + ce);
      beats = 1;
    end else begin
      base  = (int'(s) < NSRC) ? src_vals[s] : 32'd0;
      beats = (bl == 3'd0) ? 1 : (int'(bl) > 4) ? 4 : int'(bl);
    end
    for (int b = 0; b < beats; b++) begin
      c.addr = base + 32'(4 * b);
      c.idx  = 3'(b);
      c.busy = 1'b1;
      c.done = 1'b0;
      c.rd   = 1'b1;
      c.valid = (LAT == 0);
      exp_q.push_back(c);
      for (int w = 1; w <= LAT; w++) begin
        c.rd    = 1'b0;
        c.valid = (w == LAT);
        exp_q.push_back(c);
      end
    end
    c.rd = 1'b0; c.valid = 1'b0; c.busy = 1'b0; c.done = 1'b1;
    exp_q.push_back(c);

    @(negedge clk);
    apply_stimulus(do_start, do_exc, s, bl, code);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      check_cycle($sformatf("%s.c%0d", tag, k + 1), exp_q[k]);
      if (k + 1 == abort_at) begin
        reset = 1'b0;
        #1;
        check_output({tag, ".rst_addr"},  mem_addr, 32'd0);
        check_output({tag, ".rst_rd"},    32'(mem_rd), 32'd0);
        check_output({tag, ".rst_busy"},  32'(busy), 32'd0);
        check_output({tag, ".rst_done"},  32'(done), 32'd0);
        check_output({tag, ".rst_valid"}, 32'(beat_valid), 32'd0);
        start = 1'b0;
        exc_req = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check_output({tag, ".rst_hold_done"}, 32'(done), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check_output({tag, ".post_rst_done"}, 32'(done), 32'd0);
        check_output({tag, ".post_rst_busy"}, 32'(busy), 32'd0);
        return;
      end
      // Scramble every input while busy: nothing should be accepted or re-sampled.
      for (int i = 0; i < NSRC; i++) src_vals[i] = $urandom;
      apply_stimulus(1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 2'($urandom));
    end
    @(negedge clk);
    start = 1'b0;
    exc_req = 1'b0;
    c = exp_q[exp_q.size() - 1];
    c.done = 1'b0;
    check_cycle({tag, ".idle"}, c);
  endtask

  initial begin
    for (int i = 0; i < NSRC; i++) src_vals[i] = 32'd0;
    #2 reset = 1'b0;
    #1;
    check_output("reset.addr",  mem_addr, 32'd0);
    check_output("reset.rd",    32'(mem_rd), 32'd0);
    check_output("reset.valid", 32'(beat_valid), 32'd0);
    check_output("reset.busy",  32'(busy), 32'd0);
    check_output("reset.done",  32'(done), 32'd0);
    check_output("reset.idx",   32'(beat_idx), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    src_vals[0] = 32'h0000_0040;
    run_access("t1", 1'b1, 1'b0, 3'd0, 3'd1, 2'd0, 0);
    src_vals[4] = 32'h0000_0100;
    run_access("t2", 1'b1, 1'b0, 3'd4, 3'd3, 2'd0, 0);
    run_access("t3", 1'b1, 1'b1, 3'd0, 3'd4, 2'd2, 0);
    run_access("t3b", 1'b0, 1'b1, 3'd0, 3'd4, 2'd3, 0);
    run_access("t4sel", 1'b1, 1'b0, 3'd7, 3'd1, 2'd0, 0);
    src_vals[1] = 32'h1234_5678;
    run_access("t4bl0", 1'b1, 1'b0, 3'd1, 3'd0, 2'd0, 0);
    src_vals[2] = 32'h0000_2000;
    run_access("t4bl6", 1'b1, 1'b0, 3'd2, 3'd6, 2'd0, 0);
    src_vals[0] = 32'hFFFF_FFFC;
    run_access("t5wrap", 1'b1, 1'b0, 3'd0, 3'd2, 2'd0, 0);
    src_vals[3] = 32'h0000_0800;
    run_access("t6abort", 1'b1, 1'b0, 3'd3, 3'd3, 2'd0, 4);
    src_vals[5] = 32'h0000_0500;
    run_access("t6after", 1'b1, 1'b0, 3'd5, 3'd2, 2'd0, 0);

    for (int r = 0; r < 40; r++) begin
      bit use_exc;
      for (int i = 0; i < NSRC; i++) src_vals[i] = $urandom;
      if ($urandom_range(0, 3) == 0) src_vals[$urandom_range(0, NSRC - 1)] = 32'hFFFF_FFF8;
      use_exc = ($urandom_range(0, 3) == 0);
      run_access($sformatf("rnd%0d", r), use_exc ? 1'($urandom) : 1'b1, use_exc,
                 3'($urandom), 3'($urandom), 2'($urandom), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
